// File: rtl/div_pkg.sv
// Shared widths and FSM encoding for the 77/43 restoring divider.
package div_pkg;

   localparam int unsigned N_W   = 77;
   localparam int unsigned D_W   = 43;
   localparam int unsigned CNT_W = $clog2(N_W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OUT  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a quotient bit, trial-subtract D.
module div_step #(
   parameter int unsigned D_W = div_pkg::D_W
) (
   input  logic [D_W:0]   rem,
   input  logic           q_msb,
   input  logic [D_W-1:0] D,
   output logic [D_W:0]   rem_next,
   output logic           q_bit
);

   logic [D_W+1:0] rem_shifted;
   logic [D_W+1:0] trial;

   // One extra bit of headroom so the borrow is the sign of the trial difference.
   assign rem_shifted = {rem, q_msb};
   assign trial       = rem_shifted - {2'b00, D};
   assign q_bit       = ~trial[D_W+1];
   assign rem_next    = q_bit ? trial[D_W:0] : rem_shifted[D_W:0];

endmodule

// File: rtl/restoring_div_77x43.sv
// Iterative radix-2 restoring divider, 77-bit dividend by 43-bit divisor, one op in flight.
module restoring_div_77x43
   import div_pkg::*;
#(
   parameter bit FF_OUT = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N_W-1:0] N,
   input  logic [D_W-1:0] D,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N_W-1:0] Q,
   output logic [D_W-1:0] R,
   output logic           div_by_zero
);

   state_t           state_q, state_d;
   logic [N_W-1:0]   q_q, q_d;
   logic [D_W:0]     rem_q, rem_d;
   logic [D_W-1:0]   d_q, d_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dbz_q, dbz_d;
   logic             ov_q, ov_d;
   logic [D_W:0]     step_rem;
   logic             step_bit;
   logic             accept;

   assign in_ready  = (state_q == IDLE);
   assign accept    = in_valid && in_ready;
   assign out_valid = ov_q;

   div_step #(.D_W(D_W)) u_step (
      .rem      (rem_q),
      .q_msb    (q_q[N_W-1]),
      .D        (d_q),
      .rem_next (step_rem),
      .q_bit    (step_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         q_q     <= '0;
         rem_q   <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         dbz_q   <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         rem_q   <= rem_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         dbz_q   <= dbz_d;
         ov_q    <= ov_d;
      end
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      rem_d   = rem_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               d_d   = D;
               q_d   = N;
               rem_d = '0;
               cnt_d = '0;
               dbz_d = (D == '0);
               if (D == '0) begin
                  q_d   = '1;
                  rem_d = {1'b0, N[D_W-1:0]};
               end
               state_d = RUN;
            end
         end
         RUN: begin
            // A zero divisor spends one cycle here without iterating so its latency stays fixed.
            if (dbz_q) begin
               state_d = FF_OUT ? OUT : DONE;
            end else begin
               q_d   = {q_q[N_W-2:0], step_bit};
               rem_d = step_rem;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(N_W - 1)) state_d = FF_OUT ? OUT : DONE;
            end
         end
         OUT:  state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ov_d = (state_d == DONE);
   end

   generate
      if (FF_OUT) begin : g_ff_out
         logic [N_W-1:0] q_out;
         logic [D_W-1:0] r_out;
         logic           dbz_out;

         always_ff @(posedge clk) begin
            if (rst) begin
               q_out   <= '0;
               r_out   <= '0;
               dbz_out <= 1'b0;
            end else if (state_q == OUT) begin
               q_out   <= q_q;
               r_out   <= rem_q[D_W-1:0];
               dbz_out <= dbz_q;
            end else if (accept) begin
               dbz_out <= 1'b0;
            end
         end

         assign Q           = q_out;
         assign R           = r_out;
         assign div_by_zero = dbz_out;
      end else begin : g_comb_out
         assign Q           = q_q;
         assign R           = rem_q[D_W-1:0];
         assign div_by_zero = dbz_q;
      end
   endgenerate

endmodule

// File: tb/tb_restoring_div_77x43.sv
// Directed self-checking bench for restoring_div_77x43 with registered outputs.
module tb_restoring_div_77x43;

   localparam bit FF_OUT = 1'b1;
   localparam int LAT     = 77 + (FF_OUT ? 1 : 0);
   localparam int LAT_DBZ = 1 + (FF_OUT ? 1 : 0);

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [76:0] N;
   logic [42:0] D;
   logic        out_valid;
   logic        out_ready;
   logic [76:0] Q;
   logic [42:0] R;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   restoring_div_77x43 #(.FF_OUT(FF_OUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .N           (N),
      .D           (D),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .Q           (Q),
      .R           (R),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Stimulus only: issue one op from IDLE, wait for the result, capture it and release it.
   task automatic run_op(input logic [76:0] n, input logic [42:0] d,
                         output logic [76:0] q, output logic [42:0] r, output logic z,
                         output int lat, output logic busy_ok);
      in_valid = 1'b1; N = n; D = d;
      busy_ok = in_ready;
      @(posedge clk); #1;
      in_valid = 1'b0; N = '0; D = '0;
      lat = 0;
      while (!out_valid && lat < 300) begin
         if (in_ready !== 1'b0) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      if (out_valid !== 1'b1) lat = -1;
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      q = Q; r = R; z = div_by_zero;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; N = '0; D = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
      end
      checks++;
      if (Q !== '0 || R !== '0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: Q=%0h R=%0h dbz=%b, required 0/0/0", Q, R, div_by_zero);
      end
   endtask

   task automatic test_basic();
      logic [76:0] q; logic [42:0] r; logic z; int lat; logic ok;
      run_op(77'd100, 43'd7, q, r, z, lat, ok);
      checks++;
      if (q !== 77'd14 || r !== 43'd2 || z !== 1'b0) begin
         errors++;
         $display("FAIL basic_100_7: Q=%0d R=%0d dbz=%b, required 14/2/0", q, r, z);
      end
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL basic_latency: got %0d cycles, required %0d", lat, LAT);
      end
      checks++;
      if (ok !== 1'b1) begin
         errors++;
         $display("FAIL basic_in_ready: in_ready not 1 before accept and 0 while busy");
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_round_trip();
      logic [76:0] q; logic [42:0] r; logic z; int lat; logic ok;
      logic [76:0] a, b, n, exp_q;
      a = (77'd1 << 34) - 77'd1;
      b = (77'd1 << 43) - 77'd1;
      n = a * b;
      exp_q = a;
      run_op(n, b[42:0], q, r, z, lat, ok);
      checks++;
      if (q !== exp_q || r !== 43'd0 || z !== 1'b0) begin
         errors++;
         $display("FAIL round_trip: Q=%0h R=%0h dbz=%b, required %0h/0/0", q, r, z, exp_q);
      end
   endtask

   task automatic test_edges();
      logic [76:0] q; logic [42:0] r; logic z; int lat; logic ok;
      logic [76:0] ones;
      ones = '1;
      run_op(77'd5, 43'd9, q, r, z, lat, ok);
      checks++;
      if (q !== 77'd0 || r !== 43'd5) begin
         errors++;
         $display("FAIL small_over_big: Q=%0d R=%0d, required 0/5", q, r);
      end
      run_op(ones, 43'd1, q, r, z, lat, ok);
      checks++;
      if (q !== ones || r !== 43'd0 || z !== 1'b0) begin
         errors++;
         $display("FAIL max_over_one: Q=%0h R=%0h dbz=%b, required %0h/0/0", q, r, z, ones);
      end
   endtask

   task automatic test_div_by_zero();
      logic [76:0] q; logic [42:0] r; logic z; int lat; logic ok;
      logic [76:0] ones;
      ones = '1;
      run_op(77'd12345, 43'd0, q, r, z, lat, ok);
      checks++;
      if (q !== ones || r !== 43'd12345 || z !== 1'b1) begin
         errors++;
         $display("FAIL dbz_result: Q=%0h R=%0d dbz=%b, required %0h/12345/1", q, r, z, ones);
      end
      checks++;
      if (lat !== LAT_DBZ) begin
         errors++;
         $display("FAIL dbz_latency: got %0d cycles, required %0d", lat, LAT_DBZ);
      end
   endtask

   task automatic test_back_to_back();
      logic [76:0] q; logic [42:0] r; logic z; int lat; logic ok;
      int bad;
      in_valid = 1'b1; N = 77'd50; D = 43'd6;
      @(posedge clk); #1;
      lat = 0;
      while (!out_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
      end
      // in_valid stays high with fresh operands while the consumer stalls.
      N = 77'd999; D = 43'd3;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (Q !== 77'd8 || R !== 43'd2 || div_by_zero !== 1'b0 ||
             in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
         @(posedge clk); #1;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_hold: %0d stalled cycles with Q=%0d R=%0d in_ready=%b out_valid=%b, required 0 bad and 8/2/0/1",
                  bad, Q, R, in_ready, out_valid);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
      end
      run_op(77'd999, 43'd3, q, r, z, lat, ok);
      checks++;
      if (q !== 77'd333 || r !== 43'd0 || lat !== LAT) begin
         errors++;
         $display("FAIL bp_next_op: Q=%0d R=%0d lat=%0d, required 333/0/%0d", q, r, lat, LAT);
      end
   endtask

   task automatic test_mid_reset();
      logic [76:0] q; logic [42:0] r; logic z; int lat; logic ok;
      in_valid = 1'b1; N = 77'd77777; D = 43'd13;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (40) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || Q !== '0 || R !== '0) begin
         errors++;
         $display("FAIL mid_reset: out_valid=%b in_ready=%b Q=%0d R=%0d, required 0/1/0/0",
                  out_valid, in_ready, Q, R);
      end
      run_op(77'd1000, 43'd33, q, r, z, lat, ok);
      checks++;
      if (q !== 77'd30 || r !== 43'd10 || z !== 1'b0 || lat !== LAT) begin
         errors++;
         $display("FAIL post_reset_op: Q=%0d R=%0d dbz=%b lat=%0d, required 30/10/0/%0d", q, r, z, lat, LAT);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_trip();
      test_edges();
      test_div_by_zero();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
